// File: rtl/apb_req_arbiter_if.sv
// rtl/apb_req_arbiter_if.sv - requester and APB-master signal bundle for apb_req_arbiter
interface apb_req_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic [1:0]          REQ;
  logic [1:0]          REQ_WR;
  logic [2*ADDR_W-1:0] REQ_ADDR;
  logic [2*DATA_W-1:0] REQ_WDATA;
  logic [1:0]          GNT;
  logic [1:0]          DONE;
  logic                ERR;
  logic [DATA_W-1:0]   RD_DATA;
  logic                TX;
  logic                APB_SWRITE;
  logic [ADDR_W-1:0]   APB_SLV_PADDR;
  logic [DATA_W-1:0]   APB_PWDATA;
  logic                PSEL;
  logic                PENABLE;
  logic                PREADY;
  logic [DATA_W-1:0]   PRDATA;

  modport slave (
    input  REQ, REQ_WR, REQ_ADDR, REQ_WDATA, PSEL, PENABLE, PREADY, PRDATA,
    output GNT, DONE, ERR, RD_DATA, TX, APB_SWRITE, APB_SLV_PADDR, APB_PWDATA
  );

  modport master (
    output REQ, REQ_WR, REQ_ADDR, REQ_WDATA, PSEL, PENABLE, PREADY, PRDATA,
    input  GNT, DONE, ERR, RD_DATA, TX, APB_SWRITE, APB_SLV_PADDR, APB_PWDATA
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - two-requester round-robin sequencer for a shared APB master port
module apb_req_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              RST_N,
  apb_req_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BUSY, S_RESP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic              r_last;
  logic              r_win;
  logic [1:0]        r_gnt;
  logic [1:0]        r_done;
  logic              r_err;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_tx;
  logic              r_swrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;

  logic              w_win;
  logic              w_cmpl;
  logic              w_tmo;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // On a tie the requester that did not win last time gets the bus.
  assign w_win   = (bus.REQ == 2'b11) ? ~r_last : bus.REQ[1];
  assign w_addr  = w_win ? bus.REQ_ADDR[2*ADDR_W-1:ADDR_W] : bus.REQ_ADDR[ADDR_W-1:0];
  assign w_wdata = w_win ? bus.REQ_WDATA[2*DATA_W-1:DATA_W] : bus.REQ_WDATA[DATA_W-1:0];
  assign w_cmpl  = bus.PSEL & bus.PENABLE & bus.PREADY;
  assign w_tmo   = (r_cnt == TMO_LAST);

  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_last    <= 1'b1;
      r_win     <= 1'b0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
      r_tx      <= 1'b0;
      r_swrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|bus.REQ) begin
            r_win    <= w_win;
            r_gnt    <= w_win ? 2'b10 : 2'b01;
            r_swrite <= bus.REQ_WR[w_win];
            r_paddr  <= w_addr;
            r_pwdata <= w_wdata;
            r_tx     <= 1'b1;
            r_state  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_tx    <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          // Completion is tested first so a late PREADY on the last cycle still succeeds.
          if (w_cmpl) begin
            if (!r_swrite) r_rd_data <= bus.PRDATA;
            r_err   <= 1'b0;
            r_done  <= r_gnt;
            r_state <= S_RESP;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_done  <= r_gnt;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_last  <= r_win;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.GNT           = r_gnt;
  assign bus.DONE          = r_done;
  assign bus.ERR           = r_err;
  assign bus.RD_DATA       = r_rd_data;
  assign bus.TX            = r_tx;
  assign bus.APB_SWRITE    = r_swrite;
  assign bus.APB_SLV_PADDR = r_paddr;
  assign bus.APB_PWDATA    = r_pwdata;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - scoreboard bench for apb_req_arbiter with a simple APB bus responder
module tb_apb_req_arbiter;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [1:0]        gnt;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                gap;
  } cmd_t;

  typedef struct {
    logic [1:0]        done;
    logic              err;
    logic [DATA_W-1:0] rd;
    int                lat;
  } rsp_t;

  logic PCLK = 1'b0;
  logic RST_N;

  apb_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .PCLK  (PCLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  always #5 PCLK = ~PCLK;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   n_chk = 0, n_err = 0;
  int   n_tx = 0, n_done = 0, n_unexp = 0, n_gnt11 = 0, n_txwide = 0;
  int   cyc = 0, last_tx = 0;
  int   bus_wait = 0;
  logic [DATA_W-1:0] bus_rdata = '0;
  logic prev_tx = 1'b0;
  cmd_t mc;
  rsp_t mr;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus responder: PSEL in the TX cycle, PENABLE from the first BUSY cycle, PREADY after bus_wait cycles.
  initial begin
    bus.PSEL = 0; bus.PENABLE = 0; bus.PREADY = 0; bus.PRDATA = '0;
    forever begin
      @(negedge PCLK);
      if (bus.TX && RST_N) begin
        bus.PSEL = 1; bus.PENABLE = 0; bus.PREADY = 0; bus.PRDATA = bus_rdata;
        @(negedge PCLK);
        bus.PENABLE = 1;
        if (bus_wait >= 0) begin
          repeat (bus_wait) @(negedge PCLK);
          bus.PREADY = 1;
          @(negedge PCLK);
        end else begin
          for (int i = 0; i < 40 && RST_N && bus.DONE == 2'b00; i++) @(negedge PCLK);
        end
        bus.PSEL = 0; bus.PENABLE = 0; bus.PREADY = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT issues TX or DONE.
  initial begin
    forever begin
      @(negedge PCLK);
      if (bus.GNT == 2'b11) n_gnt11++;
      if (bus.TX && prev_tx) n_txwide++;
      prev_tx = bus.TX;
      if (bus.TX) begin
        if (cmd_q.size() == 0) n_unexp++;
        else begin
          mc = cmd_q.pop_front();
          chk("tx_gnt", 32'(bus.GNT), 32'(mc.gnt));
          chk("tx_swrite", 32'(bus.APB_SWRITE), 32'(mc.wr));
          chk("tx_paddr", 32'(bus.APB_SLV_PADDR), 32'(mc.addr));
          chk("tx_pwdata", 32'(bus.APB_PWDATA), 32'(mc.wdata));
          if (mc.gap > 0) chk("tx_gap", 32'(cyc - last_tx), 32'(mc.gap));
        end
        last_tx = cyc;
        n_tx++;
      end
      if (bus.DONE != 2'b00) begin
        if (rsp_q.size() == 0) n_unexp++;
        else begin
          mr = rsp_q.pop_front();
          chk("done_mask", 32'(bus.DONE), 32'(mr.done));
          chk("done_gnt", 32'(bus.GNT), 32'(mr.done));
          chk("done_err", 32'(bus.ERR), 32'(mr.err));
          chk("done_rd_data", 32'(bus.RD_DATA), 32'(mr.rd));
          chk("done_latency", 32'(cyc - last_tx), 32'(mr.lat));
        end
        n_done++;
      end
    end
  end

  task automatic wait_done(input int n);
    int start;
    start = n_done;
    for (int i = 0; i < 300 && (n_done - start) < n; i++) begin
      @(negedge PCLK); #1;
    end
    chk("wait_done", 32'(n_done - start), 32'(n));
  endtask

  task automatic set_cmd(input int id, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata);
    bus.REQ_WR[id] = wr;
    bus.REQ_ADDR[id*ADDR_W +: ADDR_W] = addr;
    bus.REQ_WDATA[id*DATA_W +: DATA_W] = wdata;
  endtask

  task automatic issue(input int id, input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input int wt, input logic [DATA_W-1:0] rdata,
                       input logic err, input logic [DATA_W-1:0] rd, input int lat);
    cmd_t c;
    rsp_t r;
    bus_wait = wt;
    bus_rdata = rdata;
    c.gnt = (id == 1) ? 2'b10 : 2'b01; c.wr = wr; c.addr = addr; c.wdata = wdata; c.gap = 0;
    r.done = c.gnt; r.err = err; r.rd = rd; r.lat = lat;
    cmd_q.push_back(c);
    rsp_q.push_back(r);
    set_cmd(id, wr, addr, wdata);
    bus.REQ = (id == 1) ? 2'b10 : 2'b01;
    wait_done(1);
    bus.REQ = 2'b00;
    repeat (2) @(negedge PCLK);
  endtask

  initial begin
    cmd_t c;
    rsp_t r;
    int   t0;
    RST_N = 0;
    bus.REQ = '0; bus.REQ_WR = '0; bus.REQ_ADDR = '0; bus.REQ_WDATA = '0;
    repeat (3) @(negedge PCLK);
    chk("rst_gnt", 32'(bus.GNT), 0);
    chk("rst_tx_done", 32'({bus.TX, bus.DONE, bus.ERR}), 0);
    chk("rst_cmd", 32'({bus.APB_SWRITE, bus.APB_SLV_PADDR, bus.APB_PWDATA}), 0);
    chk("rst_rd_data", 32'(bus.RD_DATA), 0);
    RST_N = 1;
    @(negedge PCLK);

    // write by requester 0, immediate completion
    issue(0, 1'b1, 9'h012, 8'h5A, 0, 8'h77, 1'b0, 8'h00, 2);
    // read by requester 1 with three wait cycles
    issue(1, 1'b0, 9'h1F0, 8'h00, 3, 8'hA5, 1'b0, 8'hA5, 5);
    // bus never ready: timeout, read data held
    issue(0, 1'b0, 9'h0C3, 8'h00, -1, 8'h99, 1'b1, 8'hA5, TIMEOUT + 1);
    // normal service after a timeout
    issue(1, 1'b1, 9'h101, 8'hC7, 1, 8'h66, 1'b0, 8'hA5, 3);
    // completion on the final allowed cycle beats the timeout
    issue(0, 1'b0, 9'h0FF, 8'h00, TIMEOUT - 1, 8'h3C, 1'b0, 8'h3C, TIMEOUT + 1);

    // reset during BUSY: outputs clear asynchronously, no DONE afterwards
    bus_wait = -1;
    bus_rdata = 8'h44;
    c.gnt = 2'b10; c.wr = 1'b0; c.addr = 9'h155; c.wdata = 8'h00; c.gap = 0;
    cmd_q.push_back(c);
    set_cmd(1, 1'b0, 9'h155, 8'h00);
    bus.REQ = 2'b10;
    t0 = n_tx;
    for (int i = 0; i < 20 && n_tx == t0; i++) begin
      @(negedge PCLK); #1;
    end
    chk("mid_tx_seen", 32'(n_tx - t0), 1);
    repeat (3) @(negedge PCLK);
    #2 RST_N = 0;
    #1;
    chk("mid_rst_gnt", 32'(bus.GNT), 0);
    chk("mid_rst_paddr", 32'(bus.APB_SLV_PADDR), 0);
    chk("mid_rst_rd_data", 32'(bus.RD_DATA), 0);
    chk("mid_rst_flags", 32'({bus.TX, bus.DONE, bus.ERR, bus.APB_SWRITE, bus.APB_PWDATA}), 0);
    @(negedge PCLK);
    bus.REQ = 2'b00;
    @(negedge PCLK);
    RST_N = 1;
    repeat (4) @(negedge PCLK);

    // both requesting continuously: 0 first after reset, then strict alternation
    bus_wait = 0;
    bus_rdata = 8'h77;
    set_cmd(0, 1'b1, 9'h034, 8'h11);
    set_cmd(1, 1'b1, 9'h1AB, 8'h22);
    for (int k = 0; k < 6; k++) begin
      c.gnt = (k % 2 == 1) ? 2'b10 : 2'b01;
      c.wr = 1'b1;
      c.addr = (k % 2 == 1) ? 9'h1AB : 9'h034;
      c.wdata = (k % 2 == 1) ? 8'h22 : 8'h11;
      c.gap = (k == 0) ? 0 : 4;
      r.done = c.gnt; r.err = 1'b0; r.rd = 8'h00; r.lat = 2;
      cmd_q.push_back(c);
      rsp_q.push_back(r);
    end
    bus.REQ = 2'b11;
    wait_done(6);
    bus.REQ = 2'b00;
    repeat (10) @(negedge PCLK);

    chk("cmd_q_empty", 32'(cmd_q.size()), 0);
    chk("rsp_q_empty", 32'(rsp_q.size()), 0);
    chk("unexpected_events", 32'(n_unexp), 0);
    chk("gnt_onehot", 32'(n_gnt11), 0);
    chk("tx_single_cycle", 32'(n_txwide), 0);
    chk("tx_total", 32'(n_tx), 12);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
